mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_FF00, base address of the register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (minimum 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port addr  input  32  data-memory address from the CPU (ALU result).
REQ-007 SHALL have port wdata  input  32  store data from the CPU register file.
REQ-008 SHALL have port mem_write  input  1  CPU store strobe, one cycle per store.
REQ-009 SHALL have port sel  output  1  high when addr hits this block's window; CPU read-data mux selects rdata.
REQ-010 SHALL have port rdata  output  32  combinational register read data.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while the FIFO is non-empty or the serializer is not IDLE.

Function
REQ-013 SHALL decode TXDATA at BASE_ADDR and STATUS at BASE_ADDR+4; sel high for exactly these two word addresses; addr[1:0] ignored.
REQ-014 SHALL enqueue wdata[7:0] on the edge where mem_write=1, addr=TXDATA and FIFO not full.
REQ-015 SHALL drop a TXDATA write when the FIFO is full (count before the edge), and set sticky overflow; a same-cycle dequeue does not rescue it.
REQ-016 SHALL clear overflow on any write to STATUS; a write to STATUS does not affect the FIFO.
REQ-017 SHALL return STATUS as: bit0 full, bit1 empty, bit2 serializer active, bit3 overflow, bits[8:4] FIFO count, other bits 0.
REQ-018 SHALL return 32'h0 on rdata for TXDATA reads and whenever sel=0.
REQ-019 SHALL implement the FIFO with read/write pointers wrapping modulo FIFO_DEPTH and a count 0..FIFO_DEPTH; simultaneous push and pop leaves the count unchanged.
REQ-020 SHALL implement serializer states IDLE, START, DATA, STOP.
REQ-021 SHALL, in IDLE with FIFO non-empty, pop the head byte into the shift register and go to START on that edge.
REQ-022 SHALL drive tx=0 in START, shift-register bit 0 in DATA (LSB first, 8 bits), tx=1 in STOP and IDLE.
REQ-023 SHALL hold each of START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles using a baud counter reset on every bit boundary.
REQ-024 SHALL, at the end of STOP, pop the next byte and enter START on the same edge if the FIFO is non-empty (back-to-back frames, no idle bit), else enter IDLE.
REQ-025 SHALL make tx fall on the edge after the push that makes an empty, idle FIFO non-empty (1-cycle latency); frame length is 10*CLKS_PER_BIT cycles.
REQ-026 SHALL register tx (no combinational path from inputs to tx).

Reset
REQ-027 SHALL, while reset=0, force: state IDLE, pointers and count 0, overflow 0, baud and bit counters 0, tx=1, busy=0.
REQ-028 SHALL abort any frame in progress at reset assertion, discard FIFO contents, and leave tx high; no partial byte resumes after release.
REQ-029 SHALL ignore mem_write on the edge where reset is released; reset release is assumed synchronous to clock by the system.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'h0000_FF00)
REQ-030 Single byte: store 32'h0000_00A5 to FF00 -> tx low one edge later, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, busy low after 40 cycles.
REQ-031 Status read: after reset, read FF04 -> rdata=32'h0000_0002, sel=1; read FF08 -> sel=0, rdata=0.
REQ-032 Overflow: 6 back-to-back stores 0x01..0x06 to FF00 -> 0x01 popped on first edge, 0x02..0x05 queued, 0x06 dropped, STATUS bit3=1, count=4; frames 01..05 sent back-to-back with no idle bits.
REQ-033 Overflow clear: store any value to FF04 -> bit3=0, count and frame in progress unaffected.
REQ-034 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately, busy=0, STATUS=32'h0000_0002 after release, no further tx activity.
REQ-035 Push/pop same cycle: with FIFO full, store to FF00 on the STOP-end edge -> byte dropped, overflow set, count goes 4->3.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// TXDATA at BASE_ADDR queues a byte; STATUS at BASE_ADDR+4 reports FIFO and serializer state.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic              hit_txdata;
    logic              hit_status;
    logic              armed_q;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              overflow_q;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              bit_end;
    logic              tx_d;
    logic              busy_d;
    logic              unused_ok;

    // Word-granular decode: byte offset bits and upper data bits are don't-care.
    assign hit_txdata = (addr[31:2] == BASE_ADDR[31:2]);
    assign hit_status = (addr[31:2] == STATUS_ADDR[31:2]);
    assign sel        = hit_txdata | hit_status;
    assign unused_ok  = ^{addr[1:0], wdata[31:8]};

    always_comb begin
        rdata = '0;
        if (hit_status) begin
            rdata = {23'd0, 5'(count_q), overflow_q, (state_q != S_IDLE), empty, full};
        end
    end

    // Writes on the first edge after reset release are ignored via armed_q.
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = armed_q & mem_write & hit_txdata;
    assign push     = push_req & ~full;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_req && full) begin
                overflow_q <= 1'b1;
            end else if (armed_q && mem_write && hit_status) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wdata[7:0];
        end
    end

    assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Serializer next state; tx and busy are computed from next state so they come out of flops.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
        busy_d = (count_d != '0) || (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-timeline reference model plus directed literal checks.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;
    localparam logic [31:0] TXD_A = 32'h0000_FF00;
    localparam logic [31:0] STS_A = 32'h0000_FF04;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (TXD_A),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .mem_write(mem_write),
        .sel      (sel),
        .rdata    (rdata),
        .tx       (tx),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus a cycle position within the current frame.
    logic [7:0] mq [$];
    logic       m_active;
    int         m_t;
    logic [7:0] m_byte;
    logic       m_ovf;
    logic       m_armed;
    int         n_pre;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
            m_armed  = 1'b0;
        end else begin
            n_pre = mq.size();
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) begin
                    if (n_pre > 0) begin
                        m_byte = mq.pop_front();
                        m_t    = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (n_pre > 0) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (m_armed && mem_write) begin
                if (addr[31:2] == TXD_A[31:2]) begin
                    if (n_pre == DEPTH) m_ovf = 1'b1;
                    else mq.push_back(wdata[7:0]);
                end else if (addr[31:2] == STS_A[31:2]) begin
                    m_ovf = 1'b0;
                end
            end
            m_armed = 1'b1;
        end
    end

    int          bi;
    logic        e_tx;
    logic        e_sel;
    logic [31:0] e_rdata;

    always @(negedge clock) begin
        if (reset) begin
            bi = m_t / CPB;
            if (!m_active)   e_tx = 1'b1;
            else if (bi == 0) e_tx = 1'b0;
            else if (bi >= 9) e_tx = 1'b1;
            else             e_tx = m_byte[bi-1];
            e_sel   = (addr[31:2] == TXD_A[31:2]) || (addr[31:2] == STS_A[31:2]);
            e_rdata = (addr[31:2] == STS_A[31:2]) ?
                      {23'd0, 5'(mq.size()), m_ovf, m_active, (mq.size() == 0), (mq.size() == DEPTH)} : 32'd0;
            check("model_tx", 32'(tx), 32'(e_tx));
            check("model_busy", 32'(busy), 32'(m_active || (mq.size() != 0)));
            check("model_sel", 32'(sel), 32'(e_sel));
            check("model_rdata", rdata, e_rdata);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [9:0] exp_a5;

    initial begin
        reset     = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_write = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        addr = STS_A;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_status", rdata, 32'h0000_0002);
        reset = 1'b1;
        tick();
        tick();

        // Register decode after reset
        addr = STS_A;
        @(negedge clock);
        check("status_after_rst", rdata, 32'h0000_0002);
        check("status_sel", 32'(sel), 32'd1);
        addr = 32'h0000_FF08;
        @(negedge clock);
        check("ff08_sel", 32'(sel), 32'd0);
        check("ff08_rdata", rdata, 32'd0);
        addr = TXD_A;
        @(negedge clock);
        check("txdata_sel", 32'(sel), 32'd1);
        check("txdata_rdata", rdata, 32'd0);
        addr = 32'h0000_FF07;
        @(negedge clock);
        check("ff07_rdata", rdata, 32'h0000_0002);
        addr = 32'h0000_FEFC;
        @(negedge clock);
        check("fefc_sel", 32'(sel), 32'd0);

        // Single byte A5: start, LSB-first data, stop
        exp_a5 = {1'b1, 8'hA5, 1'b0};
        store(TXD_A, 32'h0000_00A5);
        @(negedge clock);
        check("a5_before_start", 32'(tx), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clock);
            check("a5_bit", 32'(tx), 32'(exp_a5[k/CPB]));
        end
        check("a5_busy_last", 32'(busy), 32'd1);
        @(negedge clock);
        check("a5_busy_done", 32'(busy), 32'd0);
        check("a5_tx_idle", 32'(tx), 32'd1);

        // Two back-to-back bytes, model-checked
        store(TXD_A, 32'h0000_003C);
        store(TXD_A, 32'hFFFF_FF81);
        wait_idle(200);

        // Overflow: six stores, 0x06 dropped
        for (int i = 1; i <= 6; i++) begin
            addr      = TXD_A;
            wdata     = 32'(i);
            mem_write = 1'b1;
            tick();
        end
        mem_write = 1'b0;
        addr      = STS_A;
        @(negedge clock);
        check("ovf_status", rdata, 32'h0000_004D);
        store(STS_A, 32'hDEAD_BEEF);
        @(negedge clock);
        check("ovf_cleared", rdata, 32'h0000_0045);
        repeat (34) tick();
        @(negedge clock);
        check("frame1_stop", 32'(tx), 32'd1);
        addr      = TXD_A;
        wdata     = 32'h0000_0077;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        addr      = STS_A;
        @(negedge clock);
        check("frame2_start", 32'(tx), 32'd0);
        check("pushpop_full", rdata, 32'h0000_003C);
        wait_idle(250);
        @(negedge clock);
        check("drained_status", rdata, 32'h0000_000A);
        store(STS_A, 32'd0);
        @(negedge clock);
        check("final_clear", rdata, 32'h0000_0002);

        // Reset during DATA bit 3 of 0xC3
        store(TXD_A, 32'h0000_00C3);
        repeat (18) tick();
        check("c3_bit3", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        addr  = STS_A;
        @(negedge clock);
        check("post_rst_status", rdata, 32'h0000_0002);
        repeat (60) @(negedge clock);
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
